life_gen_sequencer: RTL and testbench

//  Sequencer for the serial-load 5x5 Game of Life grid datapath.
//  - Accepts a board serially and drives the grid's shift and update controls.
//  - Runs a configured number of generations; after each one it scans the board out non-destructively.
//  - Reports generation count and population, and stops early on a still-life or extinction.

---
 rtl/life_pkg.sv | 18 +
 rtl/life_cell_index.sv | 45 ++++
 rtl/life_gen_sequencer.sv | 140 ++++++++++++++
 tb/tb_life_gen_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types for the serial-load 5x5 Life sequencer.
// Grid cells are row-major, with cell 0 at the top-left.
package life_pkg;

    localparam int CELLS = 25;
    localparam int IDX_W = $clog2(CELLS);

    typedef logic [IDX_W-1:0] cell_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        STEP,
        DONE
    } state_t;

endpackage

// File: rtl/life_cell_index.sv
// Cell position counter shared by the load and scan phases.
// at_last is registered so the end-of-board decision uses no adder.
module life_cell_index
    import life_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      clear_i,
    input  logic      inc_i,
    output cell_idx_t idx_o,
    output logic      at_last_o
);

    localparam cell_idx_t LAST = cell_idx_t'(CELLS - 1);

    cell_idx_t idx_q, idx_d;
    logic      last_q, last_d;

    always_comb begin
        idx_d  = idx_q;
        last_d = last_q;
        if (clear_i) begin
            idx_d  = '0;
            last_d = 1'b0;
        end else if (inc_i) begin
            // Wrap after the final cell so the next phase starts at 0.
            idx_d  = last_q ? '0 : idx_q + 1'b1;
            last_d = !last_q && (idx_q + 1'b1 == LAST);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q  <= '0;
            last_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            last_q <= last_d;
        end
    end

    assign idx_o     = idx_q;
    assign at_last_o = last_q;

endmodule

// File: rtl/life_gen_sequencer.sv
// Sequencer for the serial-load Life grid: load, step and
// non-destructive recirculating scan with early stop detection.
module life_gen_sequencer
    import life_pkg::*;
#(
    parameter int GEN_W = 8,
    parameter int POP_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [GEN_W-1:0] cfg_gens,
    input  logic             load_valid,
    input  logic             load_bit,
    output logic             load_ready,
    output logic             grid_shift,
    output logic             grid_sin,
    output logic             grid_update,
    input  logic             grid_sout,
    output logic             out_valid,
    output logic             out_bit,
    input  logic             out_ready,
    output logic [GEN_W-1:0] gen_count,
    output logic [POP_W-1:0] pop_count,
    output logic             busy,
    output logic             done,
    output logic             stable,
    output logic             extinct
);

    state_t           state_q;
    logic [GEN_W-1:0] cfg_q;
    logic [GEN_W-1:0] gen_q;
    logic [POP_W-1:0] pop_acc_q;
    logic [POP_W-1:0] pop_q;
    logic [CELLS-1:0] snap_q;
    logic             mis_q;
    logic             stable_q;
    logic             extinct_q;

    cell_idx_t        idx;
    logic             at_last;
    logic             start_acc;
    logic             load_acc;
    logic             scan_acc;
    logic [POP_W-1:0] scan_pop;
    logic             scan_mis;

    assign start_acc = start && (state_q == IDLE || state_q == DONE);
    assign load_acc  = (state_q == LOAD) && load_valid;
    assign scan_acc  = (state_q == SCAN) && out_ready;

    // Totals including the bit being accepted this cycle.
    assign scan_pop = pop_acc_q + POP_W'(grid_sout);
    assign scan_mis = mis_q | (grid_sout != snap_q[idx]);

    life_cell_index u_idx (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (start_acc),
        .inc_i     (load_acc | scan_acc),
        .idx_o     (idx),
        .at_last_o (at_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            gen_q     <= '0;
            pop_acc_q <= '0;
            pop_q     <= '0;
            snap_q    <= '0;
            mis_q     <= 1'b0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        cfg_q     <= cfg_gens;
                        gen_q     <= '0;
                        stable_q  <= 1'b0;
                        extinct_q <= 1'b0;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_valid && at_last) begin
                        pop_acc_q <= '0;
                        mis_q     <= 1'b0;
                        state_q   <= SCAN;
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        snap_q[idx] <= grid_sout;
                        pop_acc_q   <= scan_pop;
                        mis_q       <= scan_mis;
                        if (at_last) begin
                            pop_q     <= scan_pop;
                            pop_acc_q <= '0;
                            mis_q     <= 1'b0;
                            if (gen_q != '0 && scan_pop == '0) begin
                                extinct_q <= 1'b1;
                                state_q   <= DONE;
                            end else if (gen_q != '0 && !scan_mis) begin
                                stable_q <= 1'b1;
                                state_q  <= DONE;
                            end else if (gen_q == cfg_q) begin
                                state_q <= DONE;
                            end else begin
                                state_q <= STEP;
                            end
                        end
                    end
                end
                STEP: begin
                    gen_q   <= gen_q + 1'b1;
                    state_q <= SCAN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign load_ready  = (state_q == LOAD);
    assign out_valid   = (state_q == SCAN);
    assign out_bit     = out_valid & grid_sout;
    assign grid_shift  = load_acc | scan_acc;
    assign grid_sin    = load_acc ? load_bit : (scan_acc & grid_sout);
    assign grid_update = (state_q == STEP);
    assign busy        = (state_q == LOAD) || (state_q == SCAN) || (state_q == STEP);
    assign done        = (state_q == DONE);
    assign gen_count   = gen_q;
    assign pop_count   = pop_q;
    assign stable      = stable_q;
    assign extinct     = extinct_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Directed bench for life_gen_sequencer with a behavioural
// 5x5 shift/update grid model attached to its datapath controls.
module tb_life_gen_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cfg_gens = '0;
    logic       load_valid = 1'b0;
    logic       load_bit = 1'b0;
    logic       out_ready = 1'b0;
    logic       load_ready, grid_shift, grid_sin, grid_update, grid_sout;
    logic       out_valid, out_bit, busy, done, stable, extinct;
    logic [7:0] gen_count;
    logic [4:0] pop_count;

    int          nvec = 0;
    int          nerr = 0;
    int          upd_cnt = 0;
    logic [24:0] g = '0;
    logic [24:0] scans [0:7];
    int          nscans = 0;
    bit          start_in_scan = 1'b0;
    bit          hold_ok = 1'b1;

    localparam logic [24:0] VBLINK = (25'd1 << 7) | (25'd1 << 12) | (25'd1 << 17);
    localparam logic [24:0] HBLINK = (25'd1 << 11) | (25'd1 << 12) | (25'd1 << 13);
    localparam logic [24:0] BLOCK  = (25'd1 << 6) | (25'd1 << 7) | (25'd1 << 11) | (25'd1 << 12);
    localparam logic [24:0] SINGLE = (25'd1 << 12);
    localparam logic [24:0] RANDB  = 25'h1A5C3F1;

    life_gen_sequencer #(.GEN_W(8), .POP_W(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .cfg_gens    (cfg_gens),
        .load_valid  (load_valid),
        .load_bit    (load_bit),
        .load_ready  (load_ready),
        .grid_shift  (grid_shift),
        .grid_sin    (grid_sin),
        .grid_update (grid_update),
        .grid_sout   (grid_sout),
        .out_valid   (out_valid),
        .out_bit     (out_bit),
        .out_ready   (out_ready),
        .gen_count   (gen_count),
        .pop_count   (pop_count),
        .busy        (busy),
        .done        (done),
        .stable      (stable),
        .extinct     (extinct)
    );

    always #5 clock = ~clock;

    function automatic logic [24:0] life_next(input logic [24:0] b);
        logic [24:0] n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 5 && cc >= 0 && cc < 5)
                            cnt += int'(b[rr*5+cc]);
                    end
                end
                n[r*5+c] = b[r*5+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    // Grid datapath model: cell k sits at g[k], g[0] is the serial output.
    always @(posedge clock) begin
        if (grid_update) begin
            g       <= life_next(g);
            upd_cnt <= upd_cnt + 1;
        end else if (grid_shift) begin
            g <= {grid_sin, g[24:1]};
        end
    end
    assign grid_sout = g[0];

    always @(negedge clock) begin
        if (grid_shift && grid_update) begin
            nerr++;
            $display("FAIL shift_update_overlap: both high at %0t", $time);
        end
    end

    task automatic do_start(input logic [7:0] gens);
        start    = 1'b1;
        cfg_gens = gens;
        @(negedge clock);
        start    = 1'b0;
        cfg_gens = 8'hAA;
        nvec++;
        if ({busy, load_ready, done, stable, extinct} !== 5'b11000 || gen_count !== 8'd0) begin
            nerr++;
            $display("FAIL start_to_load: busy/rdy/done/stb/ext=%b gen=%0d, want 11000 gen=0",
                     {busy, load_ready, done, stable, extinct}, gen_count);
        end
    endtask

    task automatic load_board(input logic [24:0] b, input int nbits);
        bit rdy_ok = 1'b1;
        for (int k = 0; k < nbits; k++) begin
            if (load_ready !== 1'b1) rdy_ok = 1'b0;
            load_valid = 1'b1;
            load_bit   = b[k];
            @(negedge clock);
        end
        load_valid = 1'b0;
        load_bit   = 1'b0;
        nvec++;
        if (!rdy_ok) begin
            nerr++;
            $display("FAIL load_ready: dropped during load, want 1 for %0d bits", nbits);
        end
    endtask

    task automatic scan_board(input int stall_at, input int stall_len, output logic [24:0] got);
        int   k = 0;
        int   cyc = 0;
        int   st = 0;
        logic held = 1'b0;
        got = '0;
        while (k < 25 && cyc < 200) begin
            start = (start_in_scan && k == 5);
            if (k == stall_at && st < stall_len) begin
                out_ready = 1'b0;
                if (st == 0) held = out_bit;
                else if (out_bit !== held) hold_ok = 1'b0;
                st++;
            end else begin
                out_ready = 1'b1;
                if (out_valid === 1'b1) begin
                    got[k] = out_bit;
                    k++;
                end
            end
            @(negedge clock);
            cyc++;
        end
        out_ready = 1'b0;
        start     = 1'b0;
        if (k < 25) begin
            nerr++;
            $display("FAIL scan_timeout: got %0d bits, want 25", k);
        end
    endtask

    task automatic run(input logic [24:0] b, input logic [7:0] gens,
                       input int stall_at, input int stall_len);
        bit          fin = 1'b0;
        logic [24:0] got;
        do_start(gens);
        load_board(b, 25);
        nscans  = 0;
        hold_ok = 1'b1;
        while (!fin && nscans < 8) begin
            scan_board(stall_at, (nscans == 0) ? stall_len : 0, got);
            scans[nscans] = got;
            nscans++;
            if (done === 1'b1) begin
                fin = 1'b1;
            end else begin
                nvec++;
                if (grid_update !== 1'b1) begin
                    nerr++;
                    $display("FAIL step_pulse: grid_update=%b done=%b, want update=1", grid_update, done);
                end
                @(negedge clock);
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        nvec++;
        if ({busy, done, load_ready, out_valid, out_bit, grid_shift, grid_sin, grid_update,
             stable, extinct} !== 10'b0 || gen_count !== 8'd0 || pop_count !== 5'd0) begin
            nerr++;
            $display("FAIL reset_state: flags=%b gen=%0d pop=%0d, want all 0",
                     {busy, done, load_ready, out_valid, out_bit, grid_shift, grid_sin,
                      grid_update, stable, extinct}, gen_count, pop_count);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_blinker;
        run(VBLINK, 8'd2, -1, 0);
        nvec++;
        if (nscans !== 3 || scans[0] !== VBLINK || scans[1] !== HBLINK || scans[2] !== VBLINK) begin
            nerr++;
            $display("FAIL blinker_scans: n=%0d s0=%h s1=%h s2=%h, want 3 %h %h %h",
                     nscans, scans[0], scans[1], scans[2], VBLINK, HBLINK, VBLINK);
        end
        nvec++;
        if ({done, stable, extinct} !== 3'b100 || gen_count !== 8'd2 || pop_count !== 5'd3) begin
            nerr++;
            $display("FAIL blinker_end: d/s/e=%b gen=%0d pop=%0d, want 100 gen=2 pop=3",
                     {done, stable, extinct}, gen_count, pop_count);
        end
    endtask

    task automatic test_block_stable;
        run(BLOCK, 8'd5, -1, 0);
        nvec++;
        if (nscans !== 2 || scans[0] !== BLOCK || scans[1] !== BLOCK) begin
            nerr++;
            $display("FAIL block_scans: n=%0d s0=%h s1=%h, want 2 %h %h",
                     nscans, scans[0], scans[1], BLOCK, BLOCK);
        end
        nvec++;
        if ({done, stable, extinct} !== 3'b110 || gen_count !== 8'd1 || pop_count !== 5'd4) begin
            nerr++;
            $display("FAIL block_end: d/s/e=%b gen=%0d pop=%0d, want 110 gen=1 pop=4",
                     {done, stable, extinct}, gen_count, pop_count);
        end
    endtask

    task automatic test_extinct;
        run(SINGLE, 8'd3, -1, 0);
        nvec++;
        if (nscans !== 2 || scans[0] !== SINGLE || scans[1] !== 25'd0) begin
            nerr++;
            $display("FAIL single_scans: n=%0d s0=%h s1=%h, want 2 %h 0",
                     nscans, scans[0], scans[1], SINGLE);
        end
        nvec++;
        if ({done, stable, extinct} !== 3'b101 || gen_count !== 8'd1 || pop_count !== 5'd0) begin
            nerr++;
            $display("FAIL single_end: d/s/e=%b gen=%0d pop=%0d, want 101 gen=1 pop=0",
                     {done, stable, extinct}, gen_count, pop_count);
        end
    endtask

    task automatic test_zero_gens;
        int u0;
        int exp_pop;
        u0      = upd_cnt;
        exp_pop = $countones(RANDB);
        run(RANDB, 8'd0, -1, 0);
        nvec++;
        if (nscans !== 1 || scans[0] !== RANDB || upd_cnt !== u0 || g !== RANDB) begin
            nerr++;
            $display("FAIL zero_gens_scan: n=%0d s0=%h upd=%0d grid=%h, want 1 %h 0 %h",
                     nscans, scans[0], upd_cnt - u0, g, RANDB, RANDB);
        end
        nvec++;
        if (done !== 1'b1 || gen_count !== 8'd0 || pop_count !== 5'(exp_pop)) begin
            nerr++;
            $display("FAIL zero_gens_end: done=%b gen=%0d pop=%0d, want 1 0 %0d",
                     done, gen_count, pop_count, exp_pop);
        end
    endtask

    task automatic test_stall;
        run(VBLINK, 8'd0, 10, 4);
        nvec++;
        if (!hold_ok) begin
            nerr++;
            $display("FAIL stall_hold: out_bit changed during stall, want held");
        end
        nvec++;
        if (nscans !== 1 || scans[0] !== VBLINK || g !== VBLINK) begin
            nerr++;
            $display("FAIL stall_scan: n=%0d s0=%h grid=%h, want 1 %h %h",
                     nscans, scans[0], g, VBLINK, VBLINK);
        end
    endtask

    task automatic test_reset_mid_load;
        do_start(8'd1);
        load_board(RANDB, 10);
        reset = 1'b1;
        @(negedge clock);
        nvec++;
        if ({busy, done, load_ready, out_valid, grid_shift, grid_update, stable, extinct} !== 8'b0
            || gen_count !== 8'd0 || pop_count !== 5'd0) begin
            nerr++;
            $display("FAIL reset_mid_load: flags=%b gen=%0d pop=%0d, want all 0",
                     {busy, done, load_ready, out_valid, grid_shift, grid_update, stable, extinct},
                     gen_count, pop_count);
        end
        reset = 1'b0;
        @(negedge clock);
        start_in_scan = 1'b1;
        run(VBLINK, 8'd1, -1, 0);
        start_in_scan = 1'b0;
        nvec++;
        if (nscans !== 2 || scans[0] !== VBLINK || scans[1] !== HBLINK) begin
            nerr++;
            $display("FAIL restart_scans: n=%0d s0=%h s1=%h, want 2 %h %h",
                     nscans, scans[0], scans[1], VBLINK, HBLINK);
        end
        nvec++;
        if ({done, stable, extinct} !== 3'b100 || gen_count !== 8'd1 || pop_count !== 5'd3) begin
            nerr++;
            $display("FAIL restart_end: d/s/e=%b gen=%0d pop=%0d, want 100 gen=1 pop=3",
                     {done, stable, extinct}, gen_count, pop_count);
        end
    endtask

    initial begin
        test_reset;
        test_blinker;
        test_block_stable;
        test_extinct;
        test_zero_gens;
        test_stall;
        test_reset_mid_load;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish by %0t", $time);
        $fatal(1);
    end

endmodule
